ntt_seq_ctrl: RTL and testbench
===============================

NTT_SEQ_CTRL -- requirements
Module: ntt_seq_ctrl

Interface
REQ-001 Parameter DRAIN_R2, default 9: number of DONE_RADIX2_NTT cycles that flush the radix-2 write pipeline.
REQ-002 Parameter DRAIN_R4, default 15: number of DONE_RADIX4_NTT cycles that flush the radix-4 write pipeline.
REQ-003 Parameter TIMEOUT, default 1023: maximum cycles allowed in one active stage before abort.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: asynchronous, active-low reset.
REQ-006 start  input  1: request one full NTT; sampled only in IDLE.
REQ-007 done_flag  input  3: stage-complete flags from the index FSM; 3'b001 = radix-2 last index, 3'b010 = radix-4 last index.
REQ-008 conf  output  4: configuration code driven to the index FSM.
REQ-009 busy  output  1: high in every state except IDLE.
REQ-010 done  output  1: one-cycle pulse when a transform completes normally.
REQ-011 err  output  1: one-cycle pulse when a watchdog abort occurs.
REQ-012 phase  output  3: current state encoding (0 IDLE, 1 R2, 2 D2, 3 R4, 4 D4).

Function
REQ-013 The block SHALL implement states IDLE, R2, D2, R4 and D4, held in a registered state.
REQ-014 In IDLE, conf SHALL be 4'b0000; start=1 SHALL move the block to R2 at the next edge.
REQ-015 In R2, conf SHALL be 4'b0001; done_flag==3'b001 SHALL move the block to D2 at the next edge.
REQ-016 In D2, conf SHALL be 4'b0011 for exactly DRAIN_R2 cycles, then the block SHALL move to R4.
REQ-017 In R4, conf SHALL be 4'b0010; done_flag==3'b010 SHALL move the block to D4 at the next edge.
REQ-018 In D4, conf SHALL be 4'b0100 for exactly DRAIN_R4 cycles, then the block SHALL move to IDLE with done=1 in the first IDLE cycle.
REQ-019 conf SHALL be Mealy on the stage exit: in R2 with done_flag==3'b001 conf SHALL already read 4'b0011; in R4 with done_flag==3'b010 it SHALL read 4'b0100. This keeps the FSM's registered conf from running one extra index.
REQ-020 The done_flag value SHALL be ignored except for the single code matching the current active state; other codes and X-free garbage SHALL cause no transition.
REQ-021 The drain counter SHALL be 4 bits wide, cleared on entry to D2/D4, and compared against DRAIN_x-1; DRAIN_x values 1..15 SHALL be supported.
REQ-022 The watchdog counter SHALL be 10 bits wide, cleared on entry to R2 and R4, and incremented each cycle in R2/R4.
REQ-023 When the watchdog reaches TIMEOUT without the matching done_flag, the block SHALL go to IDLE with err=1 for one cycle and done=0.
REQ-024 If the matching done_flag and the watchdog limit coincide, completion SHALL win: normal transition, no err.
REQ-025 start SHALL be ignored while busy=1; a start held high through the done cycle SHALL launch a new run from that IDLE cycle.
REQ-026 done and err SHALL never be high together, and neither SHALL be high while busy=1.

Reset
REQ-027 rst=0 SHALL immediately force state IDLE, conf=4'b0000, busy=0, done=0, err=0, phase=0, and clear both counters, regardless of clock.
REQ-028 Reset asserted mid-run SHALL abort without a done or err pulse; after release the block SHALL wait in IDLE for start.

Verification
REQ-029 Connected to the index FSM, pulse start -> conf 0001 for 128 cycles, 0011 for 9, 0010 for 512, 0100 for 15, then done=1 for one cycle; total busy = 664 cycles.
REQ-030 Force done_flag=3'b001 in R2 -> conf reads 0011 in that same cycle, and phase=2 on the next edge.
REQ-031 Hold done_flag=0 in R4 -> err=1 on the cycle after 1023 R4 cycles; conf=0000, done=0.
REQ-032 Assert start repeatedly during R4/D4 -> no restart; single done; start held through done -> conf=0001 the next cycle.
REQ-033 Drop rst asynchronously in D2 mid-drain -> outputs at reset values before the next edge; no done or err after release.
REQ-034 Override DRAIN_R2=1 and DRAIN_R4=15 -> D2 lasts exactly 1 cycle and D4 exactly 15.

Source files
------------

// File: rtl/ntt_seq_ctrl.sv
// Sequencer for one NTT run: radix-2 stage, radix-2 drain, radix-4 stage, radix-4 drain.
// Each active stage has a watchdog that aborts the run back to IDLE.
module ntt_seq_ctrl #(
    parameter int unsigned DRAIN_R2 = 9,
    parameter int unsigned DRAIN_R4 = 15,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] done_flag,
    output logic [3:0] conf,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] phase
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WDOG_W = 10;

    localparam logic [CNT_W-1:0]  DRAIN_R2_LAST = CNT_W'(DRAIN_R2 - 1);
    localparam logic [CNT_W-1:0]  DRAIN_R4_LAST = CNT_W'(DRAIN_R4 - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST     = WDOG_W'(TIMEOUT - 1);

    localparam logic [2:0] FLAG_R2 = 3'b001;
    localparam logic [2:0] FLAG_R4 = 3'b010;

    localparam logic [3:0] CONF_IDLE = 4'b0000;
    localparam logic [3:0] CONF_R2   = 4'b0001;
    localparam logic [3:0] CONF_D2   = 4'b0011;
    localparam logic [3:0] CONF_R4   = 4'b0010;
    localparam logic [3:0] CONF_D4   = 4'b0100;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_R2   = 3'd1,
        S_D2   = 3'd2,
        S_R4   = 3'd3,
        S_D4   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   drain_q, drain_d;
    logic [WDOG_W-1:0]  wdog_q,  wdog_d;
    logic               done_q,  done_d;
    logic               err_q,   err_d;

    // State, counters and completion/abort pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            drain_q <= '0;
            wdog_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            wdog_q  <= wdog_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next state, counter updates and conf; conf switches early on a stage exit
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        wdog_d  = wdog_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        conf    = CONF_IDLE;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_R2;
                    wdog_d  = '0;
                end
            end
            S_R2: begin
                conf   = CONF_R2;
                wdog_d = wdog_q + WDOG_W'(1);
                if (done_flag == FLAG_R2) begin
                    conf    = CONF_D2;
                    state_d = S_D2;
                    drain_d = '0;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_D2: begin
                conf = CONF_D2;
                if (drain_q == DRAIN_R2_LAST) begin
                    state_d = S_R4;
                    wdog_d  = '0;
                end else begin
                    drain_d = drain_q + CNT_W'(1);
                end
            end
            S_R4: begin
                conf   = CONF_R4;
                wdog_d = wdog_q + WDOG_W'(1);
                if (done_flag == FLAG_R4) begin
                    conf    = CONF_D4;
                    state_d = S_D4;
                    drain_d = '0;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_D4: begin
                conf = CONF_D4;
                if (drain_q == DRAIN_R4_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy  = (state_q != S_IDLE);
    assign phase = state_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Bench for ntt_seq_ctrl: two instances (default drains and DRAIN_R2=1) driven by the
// same stimulus, each compared every cycle against a stage/elapsed-cycle reference model.
module tb_ntt_seq_ctrl;

    localparam int TMO = 1023;
    localparam int DR2_A = 9;
    localparam int DR4_A = 15;
    localparam int DR2_B = 1;
    localparam int DR4_B = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] done_flag;

    logic [3:0] conf_a, conf_b;
    logic       busy_a, busy_b, done_a, done_b, err_a, err_b;
    logic [2:0] phase_a, phase_b;

    always #5 clk = ~clk;

    ntt_seq_ctrl #(.DRAIN_R2(DR2_A), .DRAIN_R4(DR4_A), .TIMEOUT(TMO)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .done_flag(done_flag),
        .conf(conf_a), .busy(busy_a), .done(done_a), .err(err_a), .phase(phase_a)
    );

    ntt_seq_ctrl #(.DRAIN_R2(DR2_B), .DRAIN_R4(DR4_B), .TIMEOUT(TMO)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .done_flag(done_flag),
        .conf(conf_b), .busy(busy_b), .done(done_b), .err(err_b), .phase(phase_b)
    );

    int n_vec  = 0;
    int n_fail = 0;
    int busy_len = 0;

    // Reference: which stage each instance is in and how many cycles it has spent there
    int m_ph[2];
    int m_age[2];
    bit m_done[2];
    bit m_err[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic void mreset(input int k);
        m_ph[k] = 0; m_age[k] = 0; m_done[k] = 1'b0; m_err[k] = 1'b0;
    endfunction

    function automatic int exp_conf(input int k, input logic [2:0] f);
        case (m_ph[k])
            1: return (f == 3'b001) ? 4'b0011 : 4'b0001;
            2: return 4'b0011;
            3: return (f == 3'b010) ? 4'b0100 : 4'b0010;
            4: return 4'b0100;
            default: return 4'b0000;
        endcase
    endfunction

    // Advance the model across one rising edge
    function automatic void mstep(input int k, input bit s, input logic [2:0] f);
        int dr2;
        int dr4;
        dr2 = (k == 0) ? DR2_A : DR2_B;
        dr4 = (k == 0) ? DR4_A : DR4_B;
        m_done[k] = 1'b0;
        m_err[k]  = 1'b0;
        if (!rst) begin
            mreset(k);
            return;
        end
        case (m_ph[k])
            0: if (s) begin m_ph[k] = 1; m_age[k] = 0; end
            1, 3: begin
                if (f == ((m_ph[k] == 1) ? 3'b001 : 3'b010)) begin
                    m_ph[k] = m_ph[k] + 1; m_age[k] = 0;
                end else if (m_age[k] + 1 == TMO) begin
                    m_ph[k] = 0; m_age[k] = 0; m_err[k] = 1'b1;
                end else begin
                    m_age[k]++;
                end
            end
            2: if (m_age[k] + 1 == dr2) begin m_ph[k] = 3; m_age[k] = 0; end
               else m_age[k]++;
            default: if (m_age[k] + 1 == dr4) begin m_ph[k] = 0; m_age[k] = 0; m_done[k] = 1'b1; end
               else m_age[k]++;
        endcase
    endfunction

    task automatic check_dut(input int k);
        logic [3:0] c;
        logic b, d, e;
        logic [2:0] p;
        string nm;
        if (k == 0) begin c = conf_a; b = busy_a; d = done_a; e = err_a; p = phase_a; nm = "a"; end
        else        begin c = conf_b; b = busy_b; d = done_b; e = err_b; p = phase_b; nm = "b"; end
        check({"conf_", nm},  32'(c), 32'(exp_conf(k, done_flag)));
        check({"phase_", nm}, 32'(p), 32'(m_ph[k]));
        check({"busy_", nm},  32'(b), 32'(m_ph[k] != 0));
        check({"done_", nm},  32'(d), 32'(m_done[k]));
        check({"err_", nm},   32'(e), 32'(m_err[k]));
    endtask

    task automatic cycle(input bit s, input logic [2:0] f);
        @(negedge clk);
        start = s;
        done_flag = f;
        #1;
        check_dut(0);
        check_dut(1);
        if (busy_a) busy_len++;
        mstep(0, s, f);
        mstep(1, s, f);
    endtask

    task automatic idle_cycles(input int n, input bit s);
        for (int i = 0; i < n; i++) cycle(s, 3'b000);
    endtask

    // Drop reset a few ns after an edge, check outputs before the next edge, release later
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        mreset(0);
        mreset(1);
        check_dut(0);
        check_dut(1);
        cycle(1'b0, 3'b000);
        rst = 1'b1;
    endtask

    function automatic logic [2:0] rand_flag();
        logic [2:0] garbage [6];
        int r;
        garbage = '{3'd0, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        r = int'($urandom_range(0, 63));
        if (r == 0) return 3'b001;
        if (r == 1) return 3'b010;
        return garbage[$urandom_range(0, 5)];
    endfunction

    initial begin
        rst = 1'b0;
        start = 1'b0;
        done_flag = 3'b000;
        mreset(0);
        mreset(1);
        #12;
        check_dut(0);
        check_dut(1);
        @(negedge clk);
        rst = 1'b1;

        // Full run with index-FSM-like stage lengths (128 / 512)
        busy_len = 0;
        cycle(1'b1, 3'b000);
        idle_cycles(127, 1'b0);
        cycle(1'b0, 3'b001);
        idle_cycles(520, 1'b0);
        cycle(1'b0, 3'b010);
        idle_cycles(16, 1'b0);
        check("busy_len", 32'(busy_len), 32'd664);

        // start held through the whole run, including the done cycle
        cycle(1'b1, 3'b000);
        idle_cycles(40, 1'b1);
        cycle(1'b1, 3'b001);
        idle_cycles(30, 1'b1);
        cycle(1'b1, 3'b010);
        idle_cycles(20, 1'b1);
        async_reset();

        // R2 watchdog abort, then R4 watchdog abort
        cycle(1'b1, 3'b000);
        idle_cycles(1030, 1'b0);
        cycle(1'b1, 3'b000);
        cycle(1'b0, 3'b001);
        idle_cycles(1040, 1'b0);

        // Flag coincident with the watchdog limit: completion wins
        cycle(1'b1, 3'b000);
        idle_cycles(TMO - 1, 1'b0);
        cycle(1'b0, 3'b001);
        idle_cycles(20, 1'b0);

        // Async reset in the middle of the radix-2 drain
        cycle(1'b1, 3'b000);
        cycle(1'b0, 3'b001);
        idle_cycles(4, 1'b0);
        async_reset();
        idle_cycles(30, 1'b0);

        // Random traffic with occasional asynchronous resets
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 1999) == 0) async_reset();
            else cycle(($urandom_range(0, 7) == 0), rand_flag());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
